// File: rtl/alu_fault_select_ft.sv
// Fault-tolerant ALU selector: tracks permanent per-ALU/per-class faults,
// picks a TMR/DMR/SIMPLEX ALU set per requested op class, and holds the
// ID stage in RECONF after each newly detected fault.
module alu_fault_select_ft #(
    parameter int unsigned RECONF_TIMEOUT = 16,
    parameter int unsigned N_CLASS        = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0][N_CLASS-1:0]   permanent_faulty_alu_i,
    input  logic                      op_valid_i,
    input  logic [3:0]                op_class_i,
    input  logic                      reconf_ack_i,
    output logic [3:0]                alu_sel_o,
    output logic                      sel_valid_o,
    output logic [1:0]                mode_o,
    output logic                      stall_o,
    output logic [3:0][N_CLASS-1:0]   fault_map_o,
    output logic                      new_fault_o,
    output logic                      fatal_o,
    output logic                      reconf_timeout_o,
    output logic [7:0]                reconf_count_o
);

    localparam int unsigned N_ALU = 4;
    localparam int unsigned TMO_W = $clog2(RECONF_TIMEOUT + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RECONF = 1'b1;

    localparam logic [1:0] MODE_TMR     = 2'd0;
    localparam logic [1:0] MODE_DMR     = 2'd1;
    localparam logic [1:0] MODE_SIMPLEX = 2'd2;
    localparam logic [1:0] MODE_FAIL    = 2'd3;

    logic [0:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_hit;
    logic             new_det;
    logic             accept;
    logic             class_legal;
    logic [3:0]       healthy;
    logic [3:0]       sel_c;
    logic [2:0]       n_healthy;
    logic [1:0]       mode_c;

    // Any incoming fault bit not yet recorded in the map is a new fault
    assign new_det = |(permanent_faulty_alu_i & ~fault_map_o);

    // Ops are only taken in IDLE and not in the cycle a fault forces RECONF
    assign accept = op_valid_i && (state_q == ST_IDLE) && !new_det;

    // Healthy-ALU vector for the requested class, from the registered map
    always_comb begin
        healthy     = 4'b0000;
        class_legal = 1'b0;
        for (int c = 0; c < int'(N_CLASS); c++) begin
            if (op_class_i == 4'(c)) begin
                class_legal = 1'b1;
                for (int a = 0; a < int'(N_ALU); a++) begin
                    healthy[a] = ~fault_map_o[a][c];
                end
            end
        end
    end

    // Pick up to three lowest-index healthy ALUs and derive redundancy mode
    always_comb begin
        sel_c     = 4'b0000;
        n_healthy = 3'd0;
        for (int a = 0; a < int'(N_ALU); a++) begin
            if (healthy[a]) begin
                if (n_healthy < 3'd3) begin
                    sel_c[a] = 1'b1;
                end
                n_healthy = n_healthy + 3'd1;
            end
        end
        if (!class_legal) begin
            sel_c  = 4'b0111;
            mode_c = MODE_TMR;
        end else begin
            case (n_healthy)
                3'd0:    mode_c = MODE_FAIL;
                3'd1:    mode_c = MODE_SIMPLEX;
                3'd2:    mode_c = MODE_DMR;
                default: mode_c = MODE_TMR;
            endcase
        end
    end

    // Next-state logic: reconfiguration window with restartable timeout
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_det) begin
                    state_d = ST_RECONF;
                    tmo_d   = '0;
                end
            end
            ST_RECONF: begin
                if (new_det) begin
                    tmo_d = '0;
                end else if (reconf_ack_i) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(RECONF_TIMEOUT - 1)) begin
                    state_d     = ST_IDLE;
                    tmo_d       = '0;
                    timeout_hit = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // State, fault map and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            tmo_q            <= '0;
            fault_map_o      <= '0;
            alu_sel_o        <= 4'b0111;
            mode_o           <= MODE_TMR;
            sel_valid_o      <= 1'b0;
            stall_o          <= 1'b0;
            new_fault_o      <= 1'b0;
            fatal_o          <= 1'b0;
            reconf_timeout_o <= 1'b0;
            reconf_count_o   <= 8'd0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            fault_map_o <= fault_map_o | permanent_faulty_alu_i;
            new_fault_o <= new_det;
            stall_o     <= (state_d == ST_RECONF);
            sel_valid_o <= accept;
            if (accept) begin
                alu_sel_o <= sel_c;
                mode_o    <= mode_c;
                if (class_legal && (n_healthy == 3'd0)) begin
                    fatal_o <= 1'b1;
                end
            end
            if (timeout_hit) begin
                reconf_timeout_o <= 1'b1;
            end
            if (new_det && (reconf_count_o != 8'hFF)) begin
                reconf_count_o <= reconf_count_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_fault_select_ft.sv
// Directed bench for alu_fault_select_ft: vector table plus multi-cycle
// sequences for timeout, timeout restart, op dropping and mid-RECONF reset.
module tb_alu_fault_select_ft;

    logic             clk;
    logic             rst;
    logic [3:0][8:0]  pf;
    logic             op_valid;
    logic [3:0]       op_class;
    logic             ack;
    logic [3:0]       alu_sel;
    logic             sel_valid;
    logic [1:0]       mode;
    logic             stall;
    logic [3:0][8:0]  fmap;
    logic             new_fault;
    logic             fatal;
    logic             rtmo;
    logic [7:0]       rcnt;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_fault_select_ft #(.RECONF_TIMEOUT(16), .N_CLASS(9)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .permanent_faulty_alu_i (pf),
        .op_valid_i             (op_valid),
        .op_class_i             (op_class),
        .reconf_ack_i           (ack),
        .alu_sel_o              (alu_sel),
        .sel_valid_o            (sel_valid),
        .mode_o                 (mode),
        .stall_o                (stall),
        .fault_map_o            (fmap),
        .new_fault_o            (new_fault),
        .fatal_o                (fatal),
        .reconf_timeout_o       (rtmo),
        .reconf_count_o         (rcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] pf;
        logic        ov;
        logic [3:0]  cls;
        logic        ack;
        logic        esv;
        logic [3:0]  esel;
        logic [1:0]  emode;
        logic        estall;
        logic        enf;
        logic        efatal;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vt[19];

    function automatic logic [35:0] fb(input int a, input int c);
        logic [35:0] one;
        one = 36'd1;
        return one << (a * 9 + c);
    endfunction

    function automatic vec_t mk(input logic [35:0] p, input logic ov, input logic [3:0] cls,
                                input logic ak, input logic esv, input logic [3:0] esel,
                                input logic [1:0] emode, input logic estall, input logic enf,
                                input logic efatal, input logic [7:0] ecnt);
        vec_t v;
        v.pf = p; v.ov = ov; v.cls = cls; v.ack = ak; v.esv = esv; v.esel = esel;
        v.emode = emode; v.estall = estall; v.enf = enf; v.efatal = efatal; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pf       = '0;
        op_valid = 1'b0;
        op_class = 4'd0;
        ack      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   64'(alu_sel),   64'(4'b0111));
        chk({tag, "_mode"},  64'(mode),      64'(2'd0));
        chk({tag, "_sv"},    64'(sel_valid), 64'(1'b0));
        chk({tag, "_stall"}, 64'(stall),     64'(1'b0));
        chk({tag, "_map"},   64'(fmap),      64'(36'd0));
        chk({tag, "_nf"},    64'(new_fault), 64'(1'b0));
        chk({tag, "_fatal"}, 64'(fatal),     64'(1'b0));
        chk({tag, "_tmo"},   64'(rtmo),      64'(1'b0));
        chk({tag, "_cnt"},   64'(rcnt),      64'(8'd0));
    endtask

    task automatic stall_run(input string tag, input int second_at, input int exp_len,
                             input logic [7:0] exp_cnt);
        int n_stall;
        n_stall = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 0)              pf = fb(0, 0);
            else if (cyc == second_at) pf = fb(1, 0);
            else                       pf = '0;
            tick();
            if (stall) n_stall++;
        end
        pf = '0;
        chk({tag, "_stall_len"}, 64'(n_stall), 64'(exp_len));
        chk({tag, "_timeout"},   64'(rtmo),    64'(1'b1));
        chk({tag, "_cnt"},       64'(rcnt),    64'(exp_cnt));
    endtask

    initial begin
        logic [35:0] mdl_map;

        vt[0]  = mk('0,                          1, 4'd5,  0, 1, 4'b0111, 2'd0, 0, 0, 0, 8'd0);
        vt[1]  = mk(fb(1,5),                     1, 4'd5,  0, 0, 4'b0111, 2'd0, 1, 1, 0, 8'd1);
        vt[2]  = mk('0,                          1, 4'd5,  0, 0, 4'b0111, 2'd0, 1, 0, 0, 8'd1);
        vt[3]  = mk('0,                          0, 4'd0,  1, 0, 4'b0111, 2'd0, 0, 0, 0, 8'd1);
        vt[4]  = mk('0,                          1, 4'd5,  0, 1, 4'b1101, 2'd0, 0, 0, 0, 8'd1);
        vt[5]  = mk('0,                          1, 4'd0,  0, 1, 4'b0111, 2'd0, 0, 0, 0, 8'd1);
        vt[6]  = mk('0,                          1, 4'd9,  0, 1, 4'b0111, 2'd0, 0, 0, 0, 8'd1);
        vt[7]  = mk(fb(0,8)|fb(1,8)|fb(2,8),     0, 4'd0,  0, 0, 4'b0111, 2'd0, 1, 1, 0, 8'd2);
        vt[8]  = mk('0,                          0, 4'd0,  1, 0, 4'b0111, 2'd0, 0, 0, 0, 8'd2);
        vt[9]  = mk('0,                          1, 4'd8,  0, 1, 4'b1000, 2'd2, 0, 0, 0, 8'd2);
        vt[10] = mk('0,                          0, 4'd0,  0, 0, 4'b1000, 2'd2, 0, 0, 0, 8'd2);
        vt[11] = mk(fb(3,8),                     0, 4'd0,  0, 0, 4'b1000, 2'd2, 1, 1, 0, 8'd3);
        vt[12] = mk('0,                          0, 4'd0,  1, 0, 4'b1000, 2'd2, 0, 0, 0, 8'd3);
        vt[13] = mk('0,                          1, 4'd8,  0, 1, 4'b0000, 2'd3, 0, 0, 1, 8'd3);
        vt[14] = mk('0,                          1, 4'd5,  0, 1, 4'b1101, 2'd0, 0, 0, 1, 8'd3);
        vt[15] = mk(fb(2,5),                     0, 4'd0,  0, 0, 4'b1101, 2'd0, 1, 1, 1, 8'd4);
        vt[16] = mk(fb(2,5),                     0, 4'd0,  1, 0, 4'b1101, 2'd0, 0, 0, 1, 8'd4);
        vt[17] = mk('0,                          1, 4'd5,  0, 1, 4'b1001, 2'd1, 0, 0, 1, 8'd4);
        vt[18] = mk('0,                          1, 4'd15, 0, 1, 4'b0111, 2'd0, 0, 0, 1, 8'd4);

        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk_reset_vals("por");

        // Table-driven single-cycle vectors
        mdl_map = '0;
        for (int i = 0; i < 19; i++) begin
            pf       = vt[i].pf;
            op_valid = vt[i].ov;
            op_class = vt[i].cls;
            ack      = vt[i].ack;
            mdl_map  = mdl_map | vt[i].pf;
            tick();
            chk($sformatf("v%0d_sv", i),    64'(sel_valid), 64'(vt[i].esv));
            chk($sformatf("v%0d_sel", i),   64'(alu_sel),   64'(vt[i].esel));
            chk($sformatf("v%0d_mode", i),  64'(mode),      64'(vt[i].emode));
            chk($sformatf("v%0d_stall", i), 64'(stall),     64'(vt[i].estall));
            chk($sformatf("v%0d_nf", i),    64'(new_fault), 64'(vt[i].enf));
            chk($sformatf("v%0d_fatal", i), 64'(fatal),     64'(vt[i].efatal));
            chk($sformatf("v%0d_cnt", i),   64'(rcnt),      64'(vt[i].ecnt));
            chk($sformatf("v%0d_map", i),   64'(fmap),      64'(mdl_map));
        end
        idle_inputs();

        // Reset in the middle of a RECONF window with a populated map
        pf       = fb(2, 2);
        op_valid = 1'b1;
        op_class = 4'd5;
        tick();
        chk("rr_stall_pre", 64'(stall), 64'(1'b1));
        pf  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_valid = 1'b0;
        chk_reset_vals("rr");

        // Timeout with ack held low
        do_reset();
        stall_run("to1", -1, 16, 8'd1);

        // Second fault in the 10th RECONF cycle restarts the timeout
        do_reset();
        stall_run("to2", 10, 26, 8'd2);

        // Continuous ops across a RECONF window
        do_reset();
        op_valid = 1'b1;
        op_class = 4'd0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            pf  = (cyc == 3) ? fb(3, 0) : '0;
            ack = (cyc == 6);
            tick();
            chk($sformatf("bb%0d_sv", cyc),    64'(sel_valid), 64'(!(cyc >= 3 && cyc <= 6)));
            chk($sformatf("bb%0d_stall", cyc), 64'(stall),     64'(cyc >= 3 && cyc <= 5));
            chk($sformatf("bb%0d_sel", cyc),   64'(alu_sel),   64'(4'b0111));
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
